csr_file: RTL
=============

// Module: csr_file
// PURPOSE
//   Machine-mode CSR storage for the 5-stage RV32 core. Sources the current CSR value to the CSR ALU
//   (read side) and commits the ALU's new value (write side). Also owns the cycle/instret counters,
//   interrupt gating, and trap entry/mret state updates. Sits beside the register file in ID/WB.
// PARAMETERS
//   HARTID    0    value returned by mhartid (0xF14)
//   CNT_W     64   width of the mcycle/minstret counters (split into low/high 32-bit CSRs)
// PORTS
//   clk           in   1    core clock
//   rst_n         in   1    asynchronous active-low reset
//   csr_raddr     in   12   CSR address being read (ID stage)
//   csr_rdata     out  32   current value of csr_raddr (combinational)
//   csr_we        in   1    commit a CSR write this cycle (WB stage)
//   csr_waddr     in   12   CSR address to write
//   csr_wdata     in   32   new value, already merged by the CSR ALU (RW/RS/RC)
//   instret_inc   in   1    one instruction retired this cycle
//   irq_ext       in   1    external interrupt level (MEIP)
//   irq_timer     in   1    timer interrupt level (MTIP)
//   trap_en       in   1    core is taking an interrupt this cycle
//   trap_pc       in   32   return PC saved into mepc on trap_en
//   mret          in   1    mret retiring this cycle
//   irq_req       out  1    interrupt pending and enabled; core may assert trap_en
//   trap_vector   out  32   {mtvec[31:2],2'b00} (direct mode only)
//   mepc_out      out  32   current mepc (mret target)
// BEHAVIOUR
//   - Implemented CSRs: mstatus 0x300 (MIE[3], MPIE[7], MPP[12:11] read 2'b11, others 0), mie 0x304
//     (MTIE[7], MEIE[11] writable, others 0), mtvec 0x305 ([1:0] read 0), mepc 0x341 ([1:0] read 0),
//     mip 0x344 (MTIP[7]=irq_timer, MEIP[11]=irq_ext, read-only), mcycle/mcycleh 0xB00/0xB80,
//     minstret/minstreth 0xB02/0xB82, read-only aliases cycle/cycleh 0xC00/0xC80,
//     instret/instreth 0xC02/0xC82, mhartid 0xF14. Any other address reads 0; writes ignored.
//   - Writes to read-only CSRs (mip, 0xCxx, mhartid) are ignored.
//   - Reset (rst_n=0, async): all state 0; irq_req=0, trap_vector=0, mepc_out=0, csr_rdata decodes 0
//     except mstatus MPP=2'b11 and mhartid=HARTID.
//   - Read: csr_rdata is combinational from current state. No bypass: a same-cycle write to
//     csr_raddr is seen on the next cycle (the pipeline forwards).
//   - Write: takes effect at the next posedge; visible on csr_rdata the cycle after.
//   - mcycle +1 every cycle; minstret +1 when instret_inc. Counters are CNT_W bits with carry from low
//     to high word; all-ones wraps to 0.
//   - A write to either counter half in a cycle replaces that half with csr_wdata and suppresses that
//     cycle's increment for the whole counter; the other half holds.
//   - irq_req = MIE & ((MEIE & irq_ext) | (MTIE & irq_timer)), combinational, no latching.
//   - trap_en: mepc<=trap_pc&~3, MPIE<=MIE, MIE<=0.
//   - mret: MIE<=MPIE, MPIE<=1.
//   - Priority on mstatus/mepc in the same cycle: trap_en > mret > csr_we. The losing update is dropped.
//   - csr_we to other CSRs in a trap_en/mret cycle still commits.
//   - Reset mid-operation clears all state immediately. No pending trap or write survives.
// TESTING
//   1 Reset: release rst_n; read 0x300 -> 0x00001800, 0xF14 -> HARTID, 0xB00 -> 1 one cycle after release.
//   2 R/W: write mtvec=0x00001003 -> reads 0x00001000 and trap_vector=0x1000; write 0x7C0 -> reads 0.
//   3 Counter carry: write mcycle=0xFFFFFFFF, mcycleh=5 -> two cycles later mcycleh=6,
//     mcycle=0x00000000 or 0x00000001 per cycle count; the write cycle does not increment.
//   4 Interrupt: set mie=0x800 and mstatus=0x8; raise irq_ext -> irq_req=1.
//     Pulse trap_en with trap_pc=0x208 -> mepc=0x208, mstatus=0x1880, irq_req=0.
//   5 mret: after test 4, pulse mret -> mstatus=0x1888, mepc_out unchanged, irq_req=1 while irq_ext high.
//   6 Collision: trap_en and csr_we to mstatus=0 in the same cycle -> trap result wins (MIE=0, MPIE=old MIE).
//     minstret write with instret_inc=1 -> minstret = written value exactly.

Source files
------------

// File: rtl/csr_file_if.sv
// CSR file access bundle: ID-stage read port, WB-stage write port, trap/mret controls and interrupt outputs.
// Ports: csr_raddr/csr_rdata (read), csr_we/csr_waddr/csr_wdata (write), instret_inc, irq_ext/irq_timer,
//        trap_en/trap_pc/mret (control), irq_req/trap_vector/mepc_out (status back to the core).
interface csr_file_if;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        instret_inc;
  logic        irq_ext;
  logic        irq_timer;
  logic        trap_en;
  logic [31:0] trap_pc;
  logic        mret;
  logic        irq_req;
  logic [31:0] trap_vector;
  logic [31:0] mepc_out;

  // Core pipeline side
  modport master (
    output csr_raddr, csr_we, csr_waddr, csr_wdata, instret_inc,
           irq_ext, irq_timer, trap_en, trap_pc, mret,
    input  csr_rdata, irq_req, trap_vector, mepc_out
  );

  // CSR storage side
  modport slave (
    input  csr_raddr, csr_we, csr_waddr, csr_wdata, instret_inc,
           irq_ext, irq_timer, trap_en, trap_pc, mret,
    output csr_rdata, irq_req, trap_vector, mepc_out
  );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR storage for an RV32 core: mstatus/mie/mtvec/mepc/mip, cycle/instret counters, mhartid.
// Latency: reads are combinational; writes and trap/mret updates land at the next posedge. No backpressure.
// Ports: clk, rst_n (async active-low), bus (csr_file_if.slave: read/write ports, trap controls, irq status).
module csr_file #(
  parameter logic [31:0] HARTID = 32'd0,
  parameter int          CNT_W  = 64
) (
  input logic         clk,
  input logic         rst_n,
  csr_file_if.slave   bus
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  // Architectural state
  logic             r_mie;      // mstatus.MIE
  logic             r_mpie;     // mstatus.MPIE
  logic             r_mtie;     // mie.MTIE
  logic             r_meie;     // mie.MEIE
  logic [31:2]      r_mtvec;
  logic [31:2]      r_mepc;
  logic [CNT_W-1:0] r_mcycle;
  logic [CNT_W-1:0] r_minstret;

  // Write decode. trap_en and mret own mstatus/mepc in their cycle; a colliding CSR write there is dropped.
  logic w_ctl_busy;
  logic w_we_mstatus, w_we_mepc, w_we_mie, w_we_mtvec;
  logic w_we_cyc_lo, w_we_cyc_hi, w_we_ins_lo, w_we_ins_hi;

  assign w_ctl_busy   = bus.trap_en | bus.mret;
  assign w_we_mstatus = bus.csr_we & (bus.csr_waddr == A_MSTATUS) & ~w_ctl_busy;
  assign w_we_mepc    = bus.csr_we & (bus.csr_waddr == A_MEPC)    & ~w_ctl_busy;
  assign w_we_mie     = bus.csr_we & (bus.csr_waddr == A_MIE);
  assign w_we_mtvec   = bus.csr_we & (bus.csr_waddr == A_MTVEC);
  assign w_we_cyc_lo  = bus.csr_we & (bus.csr_waddr == A_MCYCLE);
  assign w_we_cyc_hi  = bus.csr_we & (bus.csr_waddr == A_MCYCLEH);
  assign w_we_ins_lo  = bus.csr_we & (bus.csr_waddr == A_MINSTRET);
  assign w_we_ins_hi  = bus.csr_we & (bus.csr_waddr == A_MINSTRETH);

  // Counter next values: a write to either half replaces that half and suppresses the increment.
  logic [CNT_W-1:0] w_mcycle_nxt;
  logic [CNT_W-1:0] w_minstret_nxt;

  always_comb begin
    w_mcycle_nxt = r_mcycle + CNT_W'(1);
    if (w_we_cyc_lo) begin
      w_mcycle_nxt        = r_mcycle;
      w_mcycle_nxt[31:0]  = bus.csr_wdata;
    end else if (w_we_cyc_hi) begin
      w_mcycle_nxt              = r_mcycle;
      w_mcycle_nxt[CNT_W-1:32]  = bus.csr_wdata[CNT_W-33:0];
    end
  end

  always_comb begin
    w_minstret_nxt = r_minstret;
    if (w_we_ins_lo) begin
      w_minstret_nxt[31:0] = bus.csr_wdata;
    end else if (w_we_ins_hi) begin
      w_minstret_nxt[CNT_W-1:32] = bus.csr_wdata[CNT_W-33:0];
    end else if (bus.instret_inc) begin
      w_minstret_nxt = r_minstret + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mtie     <= 1'b0;
      r_meie     <= 1'b0;
      r_mtvec    <= '0;
      r_mepc     <= '0;
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (bus.trap_en) begin
        r_mepc <= bus.trap_pc[31:2];
        r_mpie <= r_mie;
        r_mie  <= 1'b0;
      end else if (bus.mret) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end else begin
        if (w_we_mstatus) begin
          r_mie  <= bus.csr_wdata[3];
          r_mpie <= bus.csr_wdata[7];
        end
        if (w_we_mepc) begin
          r_mepc <= bus.csr_wdata[31:2];
        end
      end
      if (w_we_mie) begin
        r_mtie <= bus.csr_wdata[7];
        r_meie <= bus.csr_wdata[11];
      end
      if (w_we_mtvec) begin
        r_mtvec <= bus.csr_wdata[31:2];
      end
      r_mcycle   <= w_mcycle_nxt;
      r_minstret <= w_minstret_nxt;
    end
  end

  // Zero-extend counters so the high CSR half reads correctly for any CNT_W in 33..64.
  logic [63:0] w_cyc64;
  logic [63:0] w_ins64;
  assign w_cyc64 = 64'(r_mcycle);
  assign w_ins64 = 64'(r_minstret);

  always_comb begin
    bus.csr_rdata = 32'd0;
    unique case (bus.csr_raddr)
      A_MSTATUS:             bus.csr_rdata = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie, 3'd0};
      A_MIE:                 bus.csr_rdata = {20'd0, r_meie, 3'd0, r_mtie, 7'd0};
      A_MTVEC:               bus.csr_rdata = {r_mtvec, 2'b00};
      A_MEPC:                bus.csr_rdata = {r_mepc, 2'b00};
      A_MIP:                 bus.csr_rdata = {20'd0, bus.irq_ext, 3'd0, bus.irq_timer, 7'd0};
      A_MCYCLE,   A_CYCLE:   bus.csr_rdata = w_cyc64[31:0];
      A_MCYCLEH,  A_CYCLEH:  bus.csr_rdata = w_cyc64[63:32];
      A_MINSTRET, A_INSTRET: bus.csr_rdata = w_ins64[31:0];
      A_MINSTRETH,A_INSTRETH:bus.csr_rdata = w_ins64[63:32];
      A_MHARTID:             bus.csr_rdata = HARTID;
      default:               bus.csr_rdata = 32'd0;
    endcase
  end

  assign bus.irq_req     = r_mie & ((r_meie & bus.irq_ext) | (r_mtie & bus.irq_timer));
  assign bus.trap_vector = {r_mtvec, 2'b00};
  assign bus.mepc_out    = {r_mepc, 2'b00};

endmodule
